cpu_mem_controller: RTL and testbench
=====================================

# cpu_mem_controller

Memory-side responder for the core's data and instruction ports. It accepts stores and buffers them in a small write FIFO, answers loads with a ready handshake, forwards buffered store data to later loads, and drains the FIFO on fence requests. It also serves 32-bit instruction fetches from the same on-chip doubleword RAM. It sits directly beside the CPU top-level and is driven by the core's `memory_we`, `memory_re`, address, `fence_sig` and `pc_out` outputs.

## Interface

**Parameters**

- `XLEN`, 64: data width; one RAM word is one doubleword.
- `ADDR_W`, 12: RAM word-index width, so the RAM holds 2**ADDR_W doublewords.
- `WBUF_DEPTH`, 4: write-buffer entries, power of two, at least 2.
- `READ_LATENCY`, 2: RAM access cycles for a non-forwarded load, at least 1.

**Ports**

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `io_out_addr` in XLEN: store byte address.
- `mem_out` in XLEN: store data.
- `memory_we` in 1: store request; one push per cycle while high.
- `io_in_addr` in XLEN: load byte address.
- `memory_re` in 1: load request; level, held by the core until `mem_ready`.
- `fence_sig` in 8: PI, PO, PR, PW, SI, SO, SR, SW; any nonzero bit requests a drain.
- `fence_mode` in 4: ignored; all fences are treated as full.
- `pc_out` in XLEN: fetch byte address.
- `mem_in` out XLEN: load data; valid while `mem_ready` is 1.
- `mem_ready` out 1: load complete.
- `instruction` out 32: fetched instruction word.
- `fence_busy` out 1: drain in progress.
- `wbuf_count` out $clog2(WBUF_DEPTH)+1: current buffer occupancy.
- `wbuf_overflow` out 1: sticky flag; a store was dropped.

## Operation

**Addressing**

- RAM word index is `addr[ADDR_W+2:3]`. Address bits `[2:0]` and bits above the index are ignored for data accesses.
- For fetches, `pc_out[2]` selects the upper (1) or lower (0) 32-bit half of the word.

**Write buffer**

- The write buffer is a circular FIFO of {index, data} entries.
- Push: when `memory_we` is 1 and the FIFO is not full, push one entry.
- Dropped store: when `memory_we` is 1 and the FIFO is full, drop the store and set `wbuf_overflow`. It stays set until `rst`.
- Drain: retire the oldest entry to RAM, one per cycle, when the FIFO is non-empty and the FSM is not in RD. RD owns the RAM data port.
- Push and drain in the same cycle: `wbuf_count` is unchanged. A push is accepted when full only if a drain happens in that same cycle.

**Load FSM**

- IDLE: `memory_re` = 1 is accepted.
  - If `fence_busy` is 1 or a fence request is present, go to FWAIT.
  - Otherwise, if any FIFO entry matches the index, latch the youngest matching data and go to READY.
  - Otherwise load the latency counter with READ_LATENCY and go to RD.
- FWAIT: drain until the FIFO is empty. Then perform the match/RD decision; with an empty FIFO this always goes to RD.
- RD: decrement the counter. At 0, latch the RAM word into `mem_in` and go to READY.
- READY: `mem_ready` = 1 and `mem_in` is stable. Return to IDLE when `memory_re` = 0, so one request yields exactly one response.

**Forwarding**

- A store pushed in the same cycle a load is accepted is visible to that load: the write is ordered first.
- The matching compare includes the entry being pushed.

**Fence**

- Any nonzero `fence_sig` sets `fence_busy`.
- `fence_busy` clears on the cycle after the FIFO reaches empty.
- Stores still push during a fence and extend the drain.

**Fetch**

- Registered: `instruction` reflects `pc_out` sampled on the previous edge.
- Fetches read the RAM directly and do not observe buffered stores. Self-modifying code needs a fence (PI/SI).

**Reset**

- `mem_ready` = 0, `mem_in` = 0, `instruction` = 32'h0000_0013 (NOP).
- `fence_busy` = 0, `wbuf_count` = 0, `wbuf_overflow` = 0, FSM = IDLE.
- Pending stores and any in-flight load are discarded; RAM contents are not cleared.

## Timing

- Store: push on the edge where `memory_we` is sampled 1. The earliest RAM commit is the next edge.
- Forwarded load: accepted at edge T; `mem_ready` is 1 after T+1.
- RAM load: accepted at edge T; `mem_ready` is 1 after T+READ_LATENCY+1.
- Load behind a fence: the RAM-load latency counts from the edge on which the FIFO is empty.
- `mem_ready` falls one cycle after `memory_re` is sampled 0.
- Fetch latency is 1 cycle, independent of load activity.
- A RAM write and a fetch of the same word in the same cycle: the fetch returns the old data.

## Test plan

- Reset, then pc_out = 0x4 with RAM word 0 = 0xAAAA_BBBB_1111_2222 → `instruction` = 0xAAAA_BBBB one cycle later; during reset `instruction` = 0x13.
- Store 0x0123_4567_89AB_CDEF to address 0x100, then load 0x100 on the next cycle → `mem_ready` after 1 cycle, `mem_in` = 0x0123_4567_89AB_CDEF (forwarded).
- Load 0x200 with an empty FIFO and READ_LATENCY = 2 → `mem_ready` is 1 exactly 3 cycles after accept, holds while `memory_re` = 1, and falls one cycle after `memory_re` drops.
- Hold a RAM load in RD while 5 stores arrive with WBUF_DEPTH = 4 → 4 accepted, the 5th dropped, `wbuf_overflow` = 1, and it stays 1 until `rst`.
- Push 3 stores, assert fence_sig = 8'h01 with a load in the same cycle → `fence_busy` is 1 until the FIFO empties; the load returns RAM data only after the drain.
- Assert `rst` in the middle of RD → next cycle `mem_ready` = 0, `wbuf_count` = 0, FSM in IDLE; the following load completes normally.

Source files
------------

// File: rtl/cpu_mem_controller_if.sv
// ----------------------------------------------------------------------------
// cpu_mem_controller_if
//   Bundles the core-facing store/load/fence/fetch signals of the memory
//   controller.
//   master : the core side (drives addresses, data, requests, fence, pc)
//   slave  : the controller side (returns load data, ready, instruction and
//            write-buffer status)
//   XLEN       : data/address width
//   WBUF_DEPTH : write-buffer depth; sizes the occupancy counter
// ----------------------------------------------------------------------------
interface cpu_mem_controller_if #(
    parameter int XLEN       = 64,
    parameter int WBUF_DEPTH = 4
);
    logic [XLEN-1:0]               io_out_addr;
    logic [XLEN-1:0]               mem_out;
    logic                          memory_we;
    logic [XLEN-1:0]               io_in_addr;
    logic                          memory_re;
    logic [7:0]                    fence_sig;
    logic [3:0]                    fence_mode;
    logic [XLEN-1:0]               pc_out;
    logic [XLEN-1:0]               mem_in;
    logic                          mem_ready;
    logic [31:0]                   instruction;
    logic                          fence_busy;
    logic [$clog2(WBUF_DEPTH):0]   wbuf_count;
    logic                          wbuf_overflow;

    modport master (
        output io_out_addr, mem_out, memory_we, io_in_addr, memory_re,
               fence_sig, fence_mode, pc_out,
        input  mem_in, mem_ready, instruction, fence_busy, wbuf_count,
               wbuf_overflow
    );

    modport slave (
        input  io_out_addr, mem_out, memory_we, io_in_addr, memory_re,
               fence_sig, fence_mode, pc_out,
        output mem_in, mem_ready, instruction, fence_busy, wbuf_count,
               wbuf_overflow
    );
endinterface

// File: rtl/cpu_mem_controller.sv
// ----------------------------------------------------------------------------
// cpu_mem_controller
//   Memory-side responder for the core. Stores enter a small circular write
//   buffer and retire to an on-chip doubleword RAM one per cycle. Loads are
//   answered with a ready handshake, forwarding the youngest buffered store
//   to the same word. Fences drain the buffer before a pending load reads
//   RAM. Instruction fetches read the RAM directly with one cycle latency.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cpu_mem_controller_if.slave (store, load, fence, fetch, status)
// ----------------------------------------------------------------------------
module cpu_mem_controller #(
    parameter int XLEN         = 64,
    parameter int ADDR_W       = 12,
    parameter int WBUF_DEPTH   = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_mem_controller_if.slave   bus
);
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, FWAIT, RD, READY} state_t;

    state_t              state, state_next;
    logic [XLEN-1:0]     ram       [2**ADDR_W];
    logic [ADDR_W-1:0]   fifo_idx  [WBUF_DEPTH];
    logic [XLEN-1:0]     fifo_data [WBUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic [LAT_W-1:0]    lat_cnt;
    logic [ADDR_W-1:0]   ld_idx;
    logic [XLEN-1:0]     mem_in_q;
    logic                mem_ready_q;
    logic [31:0]         instr_q;
    logic                fence_busy_q;
    logic                overflow_q;

    logic [ADDR_W-1:0]   st_idx, ld_addr_idx, pc_idx;
    logic                full, drain, push, fence_req;
    logic                fwd_hit;
    logic [XLEN-1:0]     fwd_data;
    logic                ld_start, ld_fwd, ld_ram;
    logic                unused_bits;

    assign st_idx      = bus.io_out_addr[ADDR_W+2:3];
    assign ld_addr_idx = bus.io_in_addr[ADDR_W+2:3];
    assign pc_idx      = bus.pc_out[ADDR_W+2:3];
    assign unused_bits = ^{bus.fence_mode,
                           bus.io_out_addr[XLEN-1:ADDR_W+3], bus.io_out_addr[2:0],
                           bus.io_in_addr[XLEN-1:ADDR_W+3],  bus.io_in_addr[2:0],
                           bus.pc_out[XLEN-1:ADDR_W+3],      bus.pc_out[1:0]};

    // RD owns the RAM data port, so retirement pauses while a load reads it.
    assign full       = (count == CNT_W'(WBUF_DEPTH));
    assign drain      = (count != '0) && (state != RD);
    assign push       = bus.memory_we && (!full || drain);
    assign fence_req  = |bus.fence_sig;
    assign count_next = count + CNT_W'(push) - CNT_W'(drain);

    // Youngest matching store wins: scan oldest to youngest, then let the
    // entry being pushed this cycle override everything already buffered.
    always_comb begin
        logic [PTR_W-1:0] pos;
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        pos      = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            pos = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (fifo_idx[pos] == ld_addr_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[pos];
            end
        end
        if (push && (st_idx == ld_addr_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = bus.mem_out;
        end
    end

    always_comb begin
        state_next = state;
        ld_start   = 1'b0;
        ld_fwd     = 1'b0;
        ld_ram     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.memory_re) begin
                    if (fence_busy_q || fence_req) begin
                        state_next = FWAIT;
                    end else if (fwd_hit) begin
                        ld_fwd     = 1'b1;
                        state_next = READY;
                    end else begin
                        ld_start   = 1'b1;
                        state_next = RD;
                    end
                end
            end
            // Leave on the edge that empties the buffer; nothing is left to
            // forward from, so the load always reads RAM.
            FWAIT: begin
                if (count_next == '0) begin
                    ld_start   = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                if (lat_cnt == LAT_W'(1)) begin
                    ld_ram     = 1'b1;
                    state_next = READY;
                end
            end
            READY: begin
                if (!bus.memory_re) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: RAM and buffer storage carry no reset; only the pointers and
    // counters that say which entries are live are reset.
    always_ff @(posedge clk) begin
        if (drain && !rst) ram[fifo_idx[rd_ptr]] <= fifo_data[rd_ptr];
        if (push) begin
            fifo_idx[wr_ptr]  <= st_idx;
            fifo_data[wr_ptr] <= bus.mem_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values.
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lat_cnt      <= '0;
            ld_idx       <= '0;
            mem_in_q     <= '0;
            mem_ready_q  <= 1'b0;
            instr_q      <= 32'h0000_0013;
            fence_busy_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            fence_busy_q <= fence_req || (fence_busy_q && (count != '0));
            overflow_q   <= overflow_q || (bus.memory_we && !push);
            // Ready is announced one edge after READY is entered and drops
            // on the edge that samples the request low.
            mem_ready_q  <= (state == READY) && bus.memory_re;
            instr_q      <= bus.pc_out[2] ? ram[pc_idx][63:32] : ram[pc_idx][31:0];
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (drain) rd_ptr <= rd_ptr + 1'b1;
            if (state == IDLE && bus.memory_re) ld_idx <= ld_addr_idx;
            if (ld_start)         lat_cnt <= LAT_W'(READ_LATENCY);
            else if (state == RD) lat_cnt <= lat_cnt - 1'b1;
            if (ld_fwd)      mem_in_q <= fwd_data;
            else if (ld_ram) mem_in_q <= ram[ld_idx];
        end
    end

    assign bus.mem_in        = mem_in_q;
    assign bus.mem_ready     = mem_ready_q;
    assign bus.instruction   = instr_q;
    assign bus.fence_busy    = fence_busy_q;
    assign bus.wbuf_count    = count;
    assign bus.wbuf_overflow = overflow_q;
endmodule

// File: tb/tb_cpu_mem_controller.sv
// ----------------------------------------------------------------------------
// tb_cpu_mem_controller
//   Directed bench for cpu_mem_controller. Instance dut uses the default
//   parameters; instance dut_slow uses READ_LATENCY = 6 so a load can hold
//   the RAM long enough to fill and overflow the write buffer.
// ----------------------------------------------------------------------------
module tb_cpu_mem_controller;
    logic clk = 1'b0;
    logic rst;
    int   n_checks;
    int   n_errors;

    always #5 clk = ~clk;

    cpu_mem_controller_if #(.XLEN(64), .WBUF_DEPTH(4)) bus ();
    cpu_mem_controller_if #(.XLEN(64), .WBUF_DEPTH(4)) bus2 ();

    cpu_mem_controller #(.XLEN(64), .ADDR_W(12), .WBUF_DEPTH(4), .READ_LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cpu_mem_controller #(.XLEN(64), .ADDR_W(12), .WBUF_DEPTH(4), .READ_LATENCY(6)) dut_slow (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM-path load on dut with an empty buffer: ready exactly 3 edges after accept.
    task automatic load_ram_check(input string tag, input logic [63:0] addr, input logic [63:0] exp);
        bus.memory_re  = 1'b1;
        bus.io_in_addr = addr;
        tick();
        tick();
        tick();
        check({tag, "_early"}, 64'(bus.mem_ready), 64'd0);
        tick();
        check({tag, "_ready"}, 64'(bus.mem_ready), 64'd1);
        check({tag, "_data"}, bus.mem_in, exp);
        bus.memory_re = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.io_out_addr = '0; bus.mem_out = '0; bus.memory_we = 1'b0;
        bus.io_in_addr = '0;  bus.memory_re = 1'b0; bus.fence_sig = '0;
        bus.fence_mode = '0;  bus.pc_out = 64'h4;
        bus2.io_out_addr = '0; bus2.mem_out = '0; bus2.memory_we = 1'b0;
        bus2.io_in_addr = '0;  bus2.memory_re = 1'b0; bus2.fence_sig = '0;
        bus2.fence_mode = '0;  bus2.pc_out = '0;
        tick();
        tick();

        // Reset state
        check("rst_instr", 64'(bus.instruction), 64'h13);
        check("rst_ready", 64'(bus.mem_ready), 64'd0);
        check("rst_mem_in", bus.mem_in, 64'd0);
        check("rst_fence_busy", 64'(bus.fence_busy), 64'd0);
        check("rst_count", 64'(bus.wbuf_count), 64'd0);
        check("rst_overflow", 64'(bus.wbuf_overflow), 64'd0);

        // Fetch: store word 0 through the buffer, then fetch both halves
        rst = 1'b0;
        bus.memory_we = 1'b1; bus.io_out_addr = 64'h0; bus.mem_out = 64'hAAAA_BBBB_1111_2222;
        tick();
        check("st_push_count", 64'(bus.wbuf_count), 64'd1);
        bus.memory_we = 1'b0;
        tick();
        check("st_drain_count", 64'(bus.wbuf_count), 64'd0);
        tick();
        check("fetch_hi", 64'(bus.instruction), 64'hAAAA_BBBB);
        bus.pc_out = 64'h0;
        tick();
        check("fetch_lo", 64'(bus.instruction), 64'h1111_2222);

        // Fetch of a word being written in the same cycle sees the old data
        bus.memory_we = 1'b1; bus.mem_out = 64'h5555_6666_7777_8888;
        tick();
        bus.memory_we = 1'b0;
        tick();
        check("fetch_old", 64'(bus.instruction), 64'h1111_2222);
        tick();
        check("fetch_new", 64'(bus.instruction), 64'h7777_8888);

        // Forwarded load: store then load the same word on the next cycle
        bus.memory_we = 1'b1; bus.io_out_addr = 64'h100; bus.mem_out = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.memory_we = 1'b0; bus.memory_re = 1'b1; bus.io_in_addr = 64'h100;
        tick();
        check("fwd_early", 64'(bus.mem_ready), 64'd0);
        tick();
        check("fwd_ready", 64'(bus.mem_ready), 64'd1);
        check("fwd_data", bus.mem_in, 64'h0123_4567_89AB_CDEF);
        bus.memory_re = 1'b0;
        tick();
        check("fwd_release", 64'(bus.mem_ready), 64'd0);

        // RAM load at 0x200 with an empty buffer
        bus.memory_we = 1'b1; bus.io_out_addr = 64'h200; bus.mem_out = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        bus.memory_we = 1'b0;
        tick();
        bus.memory_re = 1'b1; bus.io_in_addr = 64'h200;
        tick();
        check("rd_lat0", 64'(bus.mem_ready), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("rd_lat%0d", i), 64'(bus.mem_ready), (i == 3) ? 64'd1 : 64'd0);
        end
        check("rd_data", bus.mem_in, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        check("rd_hold", 64'(bus.mem_ready), 64'd1);
        check("rd_hold_data", bus.mem_in, 64'hDEAD_BEEF_CAFE_F00D);
        bus.memory_re = 1'b0;
        tick();
        check("rd_release", 64'(bus.mem_ready), 64'd0);

        // Fence: three stores, then fence + load + one more store together
        bus.memory_we = 1'b1;
        bus.io_out_addr = 64'h700; bus.mem_out = 64'hE1E1_E1E1_0000_0001; tick();
        bus.io_out_addr = 64'h708; bus.mem_out = 64'hE2E2_E2E2_0000_0002; tick();
        bus.io_out_addr = 64'h700; bus.mem_out = 64'hE3E3_E3E3_0000_0003; tick();
        bus.io_out_addr = 64'h708; bus.mem_out = 64'hE4E4_E4E4_0000_0004;
        bus.fence_sig = 8'h01; bus.memory_re = 1'b1; bus.io_in_addr = 64'h708;
        tick();
        check("fence_set", 64'(bus.fence_busy), 64'd1);
        check("fence_count1", 64'(bus.wbuf_count), 64'd1);
        check("fence_no_fwd", 64'(bus.mem_ready), 64'd0);
        bus.memory_we = 1'b0; bus.fence_sig = 8'h00;
        tick();
        check("fence_busy_empty", 64'(bus.fence_busy), 64'd1);
        check("fence_count0", 64'(bus.wbuf_count), 64'd0);
        tick();
        check("fence_clear", 64'(bus.fence_busy), 64'd0);
        check("fence_wait1", 64'(bus.mem_ready), 64'd0);
        tick();
        check("fence_wait2", 64'(bus.mem_ready), 64'd0);
        tick();
        check("fence_ready", 64'(bus.mem_ready), 64'd1);
        check("fence_data", bus.mem_in, 64'hE4E4_E4E4_0000_0004);
        bus.memory_re = 1'b0;
        tick();
        load_ram_check("fence_word700", 64'h700, 64'hE3E3_E3E3_0000_0003);

        // Overflow on dut_slow: five stores while a load holds the RAM in RD
        bus2.memory_re = 1'b1; bus2.io_in_addr = 64'h500;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus2.memory_we   = 1'b1;
            bus2.io_out_addr = (k == 4) ? 64'h600 : 64'h600 + 64'(8 * k);
            bus2.mem_out     = 64'hC0DE_0000_0000_0000 | 64'(k);
            tick();
            check($sformatf("ovf_count%0d", k), 64'(bus2.wbuf_count), (k < 4) ? 64'(k + 1) : 64'd4);
            check($sformatf("ovf_flag%0d", k), 64'(bus2.wbuf_overflow), (k == 4) ? 64'd1 : 64'd0);
        end
        bus2.memory_we = 1'b0;
        tick();
        tick();
        check("ovf_load_ready", 64'(bus2.mem_ready), 64'd1);
        bus2.memory_re = 1'b0;
        repeat (4) tick();
        check("ovf_drained", 64'(bus2.wbuf_count), 64'd0);
        check("ovf_sticky", 64'(bus2.wbuf_overflow), 64'd1);
        bus2.memory_re = 1'b1; bus2.io_in_addr = 64'h600;
        tick();
        repeat (6) tick();
        check("ovf_rd_early", 64'(bus2.mem_ready), 64'd0);
        tick();
        check("ovf_rd_ready", 64'(bus2.mem_ready), 64'd1);
        check("ovf_dropped_store", bus2.mem_in, 64'hC0DE_0000_0000_0000);
        bus2.memory_re = 1'b0;
        tick();

        // Reset in the middle of RD, with a store parked in the buffer
        bus.memory_re = 1'b1; bus.io_in_addr = 64'h200;
        bus.memory_we = 1'b1; bus.io_out_addr = 64'h800; bus.mem_out = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        bus.memory_we = 1'b0;
        tick();
        check("mid_rd_count", 64'(bus.wbuf_count), 64'd1);
        rst = 1'b1; bus.memory_re = 1'b0;
        tick();
        check("mid_rst_ready", 64'(bus.mem_ready), 64'd0);
        check("mid_rst_count", 64'(bus.wbuf_count), 64'd0);
        check("mid_rst_mem_in", bus.mem_in, 64'd0);
        check("mid_rst_instr", 64'(bus.instruction), 64'h13);
        check("mid_rst_overflow", 64'(bus2.wbuf_overflow), 64'd0);
        rst = 1'b0;
        tick();
        load_ram_check("post_rst_load", 64'h200, 64'hDEAD_BEEF_CAFE_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
